// File: rtl/uart_rx.sv
// uart_rx: UART receiver (start/data/stop, LSB first) with runtime baud divider and a show-ahead RX FIFO.
// Optional even-parity bit is compiled in when the macro UART_RX_PARITY_EN is defined.

module wbit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign empty_o = (r_count == {(AW+1){1'b0}});
    assign full_o  = (r_count == CNT_FULL);
    // A push while full is dropped even if a pop happens in the same cycle
    assign w_wr    = push_i && !full_o;
    assign w_rd    = pop_i && !empty_o;
    assign dout_o  = empty_o ? {WIDTH{1'b0}} : r_mem[r_rptr];

    // Storage array write port
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_re_i,
    input  logic                  rx_bit_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  parity_err_o
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic [15:0]           r_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_brk;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  r_perr;
    logic                  w_half_hit;
    logic                  w_full_hit;
    logic                  w_cnt_clr;
    logic                  w_bit_clr;
    logic                  w_shift;
    logic                  w_par_smp;
    logic                  w_par_bad;
    logic                  w_push;
    logic                  w_ferr;
    logic                  w_ovr;
    logic                  w_perr;
    logic                  w_brk_nxt;
    logic                  w_full;

`ifdef UART_RX_PARITY_EN
    logic r_par;

    function automatic logic even_par_bad(input logic [DATA_WIDTH-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    assign w_par_bad = even_par_bad(r_shreg, r_par);

    // Captured parity bit, checked together with the stop bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_par <= 1'b0;
        else if (w_par_smp) r_par <= r_rx_s;
        else                r_par <= r_par;
    end
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_half_hit = (r_cnt == ((baud_div_i >> 1) - 16'd1));
    assign w_full_hit = (r_cnt == (baud_div_i - 16'd1));

    // Two-stage synchronizer on the asynchronous serial line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_bit_i;
            r_rx_s  <= r_sync1;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        w_ovr       = 1'b0;
        w_perr      = 1'b0;
        w_brk_nxt   = r_brk;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                w_bit_clr = 1'b1;
                if (r_rx_s) w_brk_nxt = 1'b0;
                else        w_brk_nxt = r_brk;
                if (rx_en_i && !r_rx_s && !r_brk) w_state_nxt = S_START;
                else                              w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (w_half_hit) begin
                    w_cnt_clr = 1'b1;
                    w_bit_clr = 1'b1;
                    if (r_rx_s) w_state_nxt = S_IDLE;
                    else        w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full_hit) begin
                    w_cnt_clr   = 1'b1;
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_full_hit) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                    // Frame error wins; the line must return high before a new start is accepted
                    if (!r_rx_s) begin
                        w_ferr    = 1'b1;
                        w_brk_nxt = 1'b1;
                    end else if (w_par_bad) begin
                        w_perr = 1'b1;
                    end else if (w_full) begin
                        w_ovr = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_clr   = 1'b1;
                w_bit_clr   = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Baud/bit counters, shift register and registered error pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= 16'd0;
            r_bit_cnt <= {BW{1'b0}};
            r_shreg   <= {DATA_WIDTH{1'b0}};
            r_brk     <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
            if (w_bit_clr)    r_bit_cnt <= {BW{1'b0}};
            else if (w_shift) r_bit_cnt <= r_bit_cnt + BW'(1);
            else              r_bit_cnt <= r_bit_cnt;
            if (w_shift) r_shreg <= {r_rx_s, r_shreg[DATA_WIDTH-1:1]};
            else         r_shreg <= r_shreg;
            r_brk     <= w_brk_nxt;
            r_ferr    <= w_ferr;
            r_ovr     <= w_ovr;
            r_perr    <= w_perr;
        end
    end

    assign frame_err_o  = r_ferr;
    assign overrun_o    = r_ovr;
    assign parity_err_o = r_perr;
    assign full_o       = w_full;

    wbit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .din_i   (r_shreg),
        .pop_i   (rx_re_i),
        .dout_o  (dout_o),
        .empty_o (empty_o),
        .full_o  (w_full)
    );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a scoreboard queue of expected FIFO words.
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.

module tb_uart_rx;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BAUD  = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    // Start-edge to stop-sample edge: 2 sync + 1 detect + half bit, then one bit period per later bit
    localparam int SAMPLE_EDGE = 3 + BAUD / 2 + BAUD * (NBITS - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   baud_div;
    logic          rx_en;
    logic          rx_re;
    logic          rx_bit;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int perr_cnt = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .baud_div_i   (baud_div),
        .rx_en_i      (rx_en),
        .rx_re_i      (rx_re),
        .rx_bit_i     (rx_bit),
        .dout_o       (dout),
        .empty_o      (empty),
        .full_o       (full),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .parity_err_o (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err)  ferr_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) perr_cnt++;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full frame; expected outcome comes from the scoreboard model
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic flip);
        logic [NBITS-1:0] bits;
        int  f0, o0, p0, ef, eo, ep;
        logic chk;
        bits = {NBITS{1'b1}};
        bits[0] = 1'b0;
        bits[DW:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[DW+1] = (^d) ^ flip;
`endif
        bits[NBITS-1] = stop;
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
        ef = 0; eo = 0; ep = 0;
        chk = 1'b0;
        if (!stop) ef = 1;
`ifdef UART_RX_PARITY_EN
        else if (flip) ep = 1;
`endif
        else if (exp_q.size() == DEPTH) eo = 1;
        else begin
            chk = (exp_q.size() == 0);
            exp_q.push_back(d);
        end
        for (int e = 0; e < NBITS * BAUD + 4; e++) begin
            if (e % BAUD == 0) rx_bit = (e / BAUD < NBITS) ? bits[e / BAUD] : 1'b1;
            if (chk && e == SAMPLE_EDGE - 1) check("empty_before_stop", int'(empty), 1);
            if (chk && e == SAMPLE_EDGE) begin
                check("empty_after_stop", int'(empty), 0);
                check("dout_latency", int'(dout), int'(d));
            end
            tick(1);
        end
        check("frame_err_pulses", ferr_cnt - f0, ef);
        check("overrun_pulses", ovr_cnt - o0, eo);
        check("parity_err_pulses", perr_cnt - p0, ep);
    endtask

    task automatic read_one();
        logic [DW-1:0] exp_d;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            exp_d = exp_q.pop_front();
            check("read_empty", int'(empty), 0);
            check("read_dout", int'(dout), int'(exp_d));
            rx_re = 1'b1;
            tick(1);
            rx_re = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0};
        vecs[3] = '{8'h01, 1'b1, 0};
        vecs[4] = '{8'h80, 1'b1, 0};
        vecs[5] = '{8'h3C, 1'b0, 1};
        vecs[6] = '{8'h55, 1'b1, 0};

        rst_n = 1'b0; rx_bit = 1'b1; rx_en = 1'b1; rx_re = 1'b0; baud_div = 16'd16;
        tick(3);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_dout", int'(dout), 0);
        check("reset_errs", int'({frame_err, overrun, parity_err}), 0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            if (vecs[i].exp_ferr == 0) read_one();
            else check("ferr_fifo_empty", int'(empty), 1);
            check("empty_after_read", int'(empty), 1);
        end

        // Short low glitch must be rejected at the half-bit check
        begin
            int f0, o0;
            f0 = ferr_cnt; o0 = ovr_cnt;
            rx_bit = 1'b0;
            tick(4);
            rx_bit = 1'b1;
            tick(30);
            check("glitch_empty", int'(empty), 1);
            check("glitch_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        end
        send_frame(8'h96, 1'b1, 1'b0);
        read_one();

        // Fill the FIFO, then overflow by one
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == DEPTH - 2) check("full_at_15", int'(full), 0);
            if (i == DEPTH - 1) check("full_at_16", int'(full), 1);
        end
        for (int i = 0; i < DEPTH; i++) read_one();
        check("drained_empty", int'(empty), 1);
        check("drained_full", int'(full), 0);

        // Reset in the middle of 0x81 with a word already buffered
        send_frame(8'h42, 1'b1, 1'b0);
        rx_bit = 1'b0; tick(BAUD);
        rx_bit = 1'b1; tick(BAUD);
        rx_bit = 1'b0; tick(BAUD / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_empty", int'(empty), 1);
        check("midreset_dout", int'(dout), 0);
        check("midreset_full", int'(full), 0);
        exp_q.delete();
        tick(3);
        rx_bit = 1'b1;
        rst_n = 1'b1;
        tick(20);
        check("post_reset_empty", int'(empty), 1);
        send_frame(8'h7E, 1'b1, 1'b0);
        read_one();
        check("post_reset_drained", int'(empty), 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b0);
        read_one();
        send_frame(8'h03, 1'b1, 1'b1);
        check("parity_bad_empty", int'(empty), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
